// File: rtl/stream_to_bram_capture_pkg.sv
// capture_pkg: shared types and constants for the stream-to-BRAM capture path.
// The pad length matches the upstream BRAM-to-stream source.
package capture_pkg;

    typedef enum logic [1:0] {
        SYNC,
        CAPTURE,
        DRAIN,
        DROP
    } state_t;

    localparam int LANE_WIDTH            = 24;
    localparam int BANK_COUNT            = 2;
    localparam int DEFAULT_CAPTURE_WORDS = 1024;
    localparam int FILTER_SIZE           = 32;

    function automatic logic [31:0] sext_lane(input logic [LANE_WIDTH-1:0] x);
        return {{(32-LANE_WIDTH){x[LANE_WIDTH-1]}}, x};
    endfunction

endpackage

// File: rtl/stream_to_bram_capture_if.sv
// stream_to_bram_capture_if: AXI4-Stream sample channel between source and capture.
interface stream_to_bram_capture_if #(
    parameter int W = 48
);

    logic         TVALID;
    logic         TREADY;
    logic         TLAST;
    logic [W-1:0] TDATA;
    logic [W/8-1:0] TSTRB;

    modport master (output TVALID, TDATA, TSTRB, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TSTRB, TLAST, output TREADY);

endinterface

// File: rtl/stream_to_bram_capture_bank_tracker.sv
// bank_tracker: ping-pong bank ownership; a bank stays full until the reader releases it.
module bank_tracker
    import capture_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_i,
    input  logic [BANK_COUNT-1:0] release_i,
    input  logic                  query_i,
    output logic                  wr_bank_o,
    output logic [BANK_COUNT-1:0] full_o,
    output logic                  free_o
);

    logic                  wr_bank_q, wr_bank_d;
    logic [BANK_COUNT-1:0] full_q, full_d;

    // Set after release so a simultaneous fill and release leaves the bank full
    always_comb begin
        full_d = full_q & ~release_i;
        if (set_i) full_d[wr_bank_q] = 1'b1;
        wr_bank_d = wr_bank_q ^ set_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
        end
    end

    // A release arriving with the query already frees the bank
    assign free_o    = ~full_q[query_i] | release_i[query_i];
    assign wr_bank_o = wr_bank_q;
    assign full_o    = full_q;

endmodule

// File: rtl/stream_to_bram_capture.sv
// stream_to_bram_capture: stores the first CAPTURE_WORDS beats of each TLAST frame
// into a two-bank BRAM and reports completed banks, overruns and short frames.
module stream_to_bram_capture
    import capture_pkg::*;
#(
    parameter int BRAM_DEPTH_BITS    = 11,
    parameter int S_AXIS_TDATA_WIDTH = 48,
    parameter int BRAM_TDATA_WIDTH   = 64,
    parameter int CAPTURE_WORDS      = DEFAULT_CAPTURE_WORDS
) (
    input  logic                        S_AXIS_ACLK,
    input  logic                        S_AXIS_ARESET,
    stream_to_bram_capture_if.slave     s_axis,
    input  logic                        CAPTURE_EN,
    input  logic [BANK_COUNT-1:0]       BANK_RELEASE,
    output logic [BRAM_DEPTH_BITS-1:0]  BRAM_ADDR,
    output logic [BRAM_TDATA_WIDTH-1:0] BRAM_DATAOUT,
    output logic                        BRAM_WE,
    output logic                        FRAME_DONE,
    output logic                        DONE_BANK,
    output logic [BANK_COUNT-1:0]       BANK_FULL,
    output logic                        OVERRUN,
    output logic                        SHORT_FRAME,
    input  logic                        STATUS_CLR
);

    localparam int               CTR_W    = BRAM_DEPTH_BITS - 1;
    localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(CAPTURE_WORDS - 1);

    state_t                        state_q, state_d;
    logic [CTR_W-1:0]              ctr_q, ctr_d;
    logic                          tready_q;
    logic                          we_q;
    logic [BRAM_DEPTH_BITS-1:0]    addr_q;
    logic [BRAM_TDATA_WIDTH-1:0]   data_q;
    logic                          done_q, done_bank_q;
    logic                          ovr_q, ovr_d;
    logic                          short_q, short_d;
    logic                          beat, boundary, set_full, short_err, ovr_err;
    logic                          wr_bank, bank_free;
    logic [S_AXIS_TDATA_WIDTH-1:0] tdata;
    logic                          unused_tstrb;

    assign tdata        = s_axis.TDATA;
    assign unused_tstrb = ^s_axis.TSTRB;
    assign beat         = s_axis.TVALID & tready_q;

    bank_tracker u_banks (
        .clk       (S_AXIS_ACLK),
        .rst       (S_AXIS_ARESET),
        .set_i     (set_full),
        .release_i (BANK_RELEASE),
        .query_i   (set_full ? ~wr_bank : wr_bank),
        .wr_bank_o (wr_bank),
        .full_o    (BANK_FULL),
        .free_o    (bank_free)
    );

    // Every TLAST that ends a frame funnels through one boundary check; a completed
    // frame queries the bank it is about to toggle to.
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        boundary  = 1'b0;
        set_full  = 1'b0;
        short_err = 1'b0;
        case (state_q)
            SYNC, DROP: boundary = beat & s_axis.TLAST;
            CAPTURE: begin
                if (beat) begin
                    ctr_d     = (ctr_q == LAST_IDX || s_axis.TLAST) ? '0 : ctr_q + 1'b1;
                    boundary  = s_axis.TLAST;
                    set_full  = s_axis.TLAST & (ctr_q == LAST_IDX);
                    short_err = s_axis.TLAST & (ctr_q != LAST_IDX);
                    state_d   = (ctr_q == LAST_IDX && !s_axis.TLAST) ? DRAIN : CAPTURE;
                end
            end
            DRAIN: begin
                boundary = beat & s_axis.TLAST;
                set_full = beat & s_axis.TLAST;
            end
        endcase
        if (boundary) state_d = !CAPTURE_EN ? SYNC : bank_free ? CAPTURE : DROP;
        ovr_err = boundary & CAPTURE_EN & ~bank_free;
        ovr_d   = ovr_err | (ovr_q & ~STATUS_CLR);
        short_d = short_err | (short_q & ~STATUS_CLR);
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state_q     <= SYNC;
            ctr_q       <= '0;
            tready_q    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            done_bank_q <= 1'b0;
            ovr_q       <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            tready_q    <= 1'b1;
            we_q        <= beat & (state_q == CAPTURE);
            addr_q      <= {wr_bank, ctr_q};
            data_q      <= BRAM_TDATA_WIDTH'({sext_lane(tdata[2*LANE_WIDTH-1:LANE_WIDTH]),
                                              sext_lane(tdata[LANE_WIDTH-1:0])});
            done_q      <= set_full;
            done_bank_q <= set_full ? wr_bank : done_bank_q;
            ovr_q       <= ovr_d;
            short_q     <= short_d;
        end
    end

    assign s_axis.TREADY = tready_q;
    assign BRAM_WE       = we_q;
    assign BRAM_ADDR     = addr_q;
    assign BRAM_DATAOUT  = data_q;
    assign FRAME_DONE    = done_q;
    assign DONE_BANK     = done_bank_q;
    assign OVERRUN       = ovr_q;
    assign SHORT_FRAME   = short_q;

endmodule

// File: tb/tb_stream_to_bram_capture.sv
// tb_stream_to_bram_capture: frame-table driven bench with a beat-level reference model
// that predicts every BRAM write, done pulse and status flag.
module tb_stream_to_bram_capture;
    import capture_pkg::*;

    localparam int DB   = 11;
    localparam int CW   = 1024;
    localparam int BANK = 1 << (DB - 1);
    localparam int FL   = CW + FILTER_SIZE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_to_bram_capture_if #(.W(48)) s_axis ();

    logic          cap_en = 1'b0;
    logic [1:0]    rel = 2'b00;
    logic          clr = 1'b0;
    logic [DB-1:0] addr;
    logic [63:0]   dout;
    logic          we, done, done_bank, ovr, shrt;
    logic [1:0]    full;

    stream_to_bram_capture dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .s_axis        (s_axis),
        .CAPTURE_EN    (cap_en),
        .BANK_RELEASE  (rel),
        .BRAM_ADDR     (addr),
        .BRAM_DATAOUT  (dout),
        .BRAM_WE       (we),
        .FRAME_DONE    (done),
        .DONE_BANK     (done_bank),
        .BANK_FULL     (full),
        .OVERRUN       (ovr),
        .SHORT_FRAME   (shrt),
        .STATUS_CLR    (clr)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: target bank of the current frame (-1 = not stored) and beat index
    int       tgt;
    int       idx;
    bit       m_bank;
    bit [1:0] m_full;
    bit       m_ovr, m_sh;

    int o_wr, o_done, o_first;
    bit o_db;

    typedef struct {
        int       len;
        bit       gap;
        bit       en;
        int       en_off;
        bit [1:0] rel;
        bit       clr;
        int       wr;
        int       dn;
        bit       db;
        bit [1:0] full;
        bit       ov;
        bit       sh;
        int       first;
    } row_t;

    row_t rows[13];

    task automatic model_reset();
        tgt = -1; idx = 0; m_bank = 0; m_full = 2'b00; m_ovr = 0; m_sh = 0;
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input bit v, input bit [47:0] d, input bit l, input bit [1:0] r, input bit c);
        bit          e_we, e_done, e_db, err_o, err_s, free;
        bit [1:0]    setm;
        logic [DB-1:0] e_addr;
        logic [63:0] e_data;
        int          sa, sb;
        logic [82:0] got, exp;
        s_axis.TVALID = v; s_axis.TDATA = d; s_axis.TLAST = l; s_axis.TSTRB = 6'h3f;
        rel = r; clr = c;
        e_we = 0; e_done = 0; e_db = 0; err_o = 0; err_s = 0; setm = 0; e_addr = '0; e_data = '0;
        if (v) begin
            if (tgt >= 0 && idx < CW) begin
                sa = d[23] ? int'(d[23:0]) - (1 << 24) : int'(d[23:0]);
                sb = d[47] ? int'(d[47:24]) - (1 << 24) : int'(d[47:24]);
                e_we = 1; e_addr = DB'(tgt * BANK + idx); e_data = {sb, sa};
            end
            if (l) begin
                if (tgt >= 0) begin
                    if (idx >= CW - 1) begin
                        e_done = 1; e_db = m_bank; setm[m_bank] = 1; m_bank = !m_bank;
                    end else err_s = 1;
                end
                free = !m_full[m_bank] || r[m_bank];
                if (!cap_en) tgt = -1;
                else if (!free) begin tgt = -1; err_o = 1; end
                else tgt = int'(m_bank);
                idx = 0;
            end else idx++;
        end
        m_full = (m_full & ~r) | setm;
        m_ovr = err_o | (m_ovr & !c);
        m_sh  = err_s | (m_sh & !c);
        @(posedge clk); #1;
        got = {s_axis.TREADY, we, we ? addr : '0, we ? dout : 64'h0, done, done ? done_bank : 1'b0, full, ovr, shrt};
        exp = {1'b1, e_we, e_addr, e_data, e_done, e_db, m_full, m_ovr, m_sh};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL cycle@%0t: tready/we/addr/data/done/bank/full/ovr/short got %b/%b/%h/%h/%b/%b/%b/%b/%b expected 1/%b/%h/%h/%b/%b/%b/%b/%b",
                     $time, s_axis.TREADY, we, addr, dout, done, done_bank, full, ovr, shrt,
                     e_we, e_addr, e_data, e_done, e_db, m_full, m_ovr, m_sh);
        end
        if (we) begin
            if (o_wr == 0) o_first = int'(addr);
            o_wr++;
        end
        if (done) begin o_done++; o_db = done_bank; end
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 48'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)), 2'b00, 0);
    endtask

    task automatic frame(input int len, input bit gap, input int en_off);
        bit [47:0] d;
        for (int i = 0; i < len; i++) begin
            if (gap && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) idle();
            if (i == en_off) cap_en = 0;
            d = (i == 0) ? 48'h800001_000005 : 48'({$urandom(), $urandom()});
            step(1, d, i == len - 1, 2'b00, 0);
        end
        repeat (2) step(0, 48'h0, 0, 2'b00, 0);
    endtask

    task automatic clear_obs();
        o_wr = 0; o_done = 0; o_first = -1; o_db = 0;
    endtask

    initial begin
        rows[0]  = '{FL,  0, 1, -1, 2'b00, 0,    0, 0, 0, 2'b00, 0, 0, -1};
        rows[1]  = '{FL,  0, 1, -1, 2'b00, 0, 1024, 1, 0, 2'b01, 0, 0,  0};
        rows[2]  = '{FL,  0, 1, -1, 2'b00, 0, 1024, 1, 1, 2'b11, 1, 0, 1024};
        rows[3]  = '{FL,  0, 1, -1, 2'b00, 0,    0, 0, 0, 2'b11, 1, 0, -1};
        rows[4]  = '{FL,  0, 1, -1, 2'b01, 1,    0, 0, 0, 2'b10, 0, 0, -1};
        rows[5]  = '{FL,  0, 1, -1, 2'b00, 0, 1024, 1, 0, 2'b11, 1, 0,  0};
        rows[6]  = '{FL,  0, 1, -1, 2'b10, 1,    0, 0, 0, 2'b01, 0, 0, -1};
        rows[7]  = '{500, 0, 1, -1, 2'b00, 0,  500, 0, 0, 2'b01, 0, 1, 1024};
        rows[8]  = '{FL,  0, 1, -1, 2'b00, 0, 1024, 1, 1, 2'b11, 1, 1, 1024};
        rows[9]  = '{FL,  1, 1, -1, 2'b11, 1,    0, 0, 0, 2'b00, 0, 0, -1};
        rows[10] = '{FL,  1, 1, -1, 2'b00, 0, 1024, 1, 0, 2'b01, 0, 0,  0};
        rows[11] = '{FL,  0, 1, 100, 2'b00, 0, 1024, 1, 1, 2'b11, 0, 0, 1024};
        rows[12] = '{FL,  0, 0, -1, 2'b11, 0,    0, 0, 0, 2'b00, 0, 0, -1};

        s_axis.TVALID = 0; s_axis.TDATA = '0; s_axis.TLAST = 0; s_axis.TSTRB = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {s_axis.TREADY, we, addr, dout, done, done_bank, full, ovr, shrt}, 0);
        rst = 0;
        model_reset();
        idle();

        for (int r = 0; r < 13; r++) begin
            clear_obs();
            if (rows[r].rel != 0 || rows[r].clr) step(0, 48'h0, 0, rows[r].rel, rows[r].clr);
            cap_en = rows[r].en;
            frame(rows[r].len, rows[r].gap, rows[r].en_off);
            chk($sformatf("row%0d_writes", r), o_wr, rows[r].wr);
            chk($sformatf("row%0d_done", r), o_done, rows[r].dn);
            if (rows[r].dn > 0) chk($sformatf("row%0d_done_bank", r), o_db, rows[r].db);
            if (rows[r].wr > 0) chk($sformatf("row%0d_first_addr", r), o_first, rows[r].first);
            chk($sformatf("row%0d_bank_full", r), full, rows[r].full);
            chk($sformatf("row%0d_overrun", r), ovr, rows[r].ov);
            chk($sformatf("row%0d_short", r), shrt, rows[r].sh);
        end

        // Reset in the middle of a bank-1 frame throws away the partial frame and bank state
        cap_en = 1;
        clear_obs();
        frame(FL, 0, -1);
        chk("rs_sync_writes", o_wr, 0);
        frame(FL, 0, -1);
        chk("rs_bank0_done", o_done, 1);
        clear_obs();
        for (int i = 0; i < 300; i++) step(1, 48'({$urandom(), $urandom()}), 0, 2'b00, 0);
        chk("rs_partial_writes", o_wr, 300);
        chk("rs_pre_full", full, 2'b01);
        s_axis.TVALID = 1; s_axis.TLAST = 1;
        #2 rst = 1;
        #1;
        chk("rs_async_outputs", {s_axis.TREADY, we, addr, dout, done, full}, 0);
        repeat (3) @(negedge clk);
        chk("rs_held_outputs", {s_axis.TREADY, we, done, full, ovr, shrt}, 0);
        rst = 0;
        model_reset();
        idle();
        clear_obs();
        frame(FL, 0, -1);
        chk("rs_post_sync_writes", o_wr, 0);
        clear_obs();
        frame(FL, 0, -1);
        chk("rs_post_writes", o_wr, 1024);
        chk("rs_post_first", o_first, 0);
        chk("rs_post_done_bank", o_db, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
